// File: rtl/cnn_accel_wrapper.sv
// CNN accelerator top: channel-averaging conv front-end feeding a three-layer
// ternary-weight fully-connected pipeline with a three-word output buffer.

// One sequential FC layer: one multiply-accumulate per cycle, weights generated on the fly.
module fc_layer #(
   parameter int N_IN  = 8,
   parameter int N_OUT = 4,
   parameter int DW    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                start,
   input  logic                act_en,
   input  logic                take,
   input  logic [N_IN*DW-1:0]  in_vec,
   output logic                busy,
   output logic                done,
   output logic [N_OUT*DW-1:0] out_vec
);
   localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state;
   logic signed [DW-1:0]   x_reg [N_IN];
   logic signed [DW-1:0]   res   [N_OUT];
   logic [IW-1:0]          in_idx;
   logic [OW-1:0]          out_idx;
   logic signed [23:0]     acc;
   logic signed [23:0]     x_ext;
   logic signed [23:0]     term;
   logic signed [23:0]     acc_next;
   logic [7:0]             wsum;
   logic [1:0]             wsel;
   logic signed [DW-1:0]   neuron;
   logic                   last_in;
   logic                   last_out;

   // Ternary weight ((i + 2o) mod 3) - 1 selects +x, 0 or -x; then saturate and optional ReLU.
   always_comb begin
      wsum     = 8'(in_idx) + 8'(out_idx) * 8'd2;
      wsel     = 2'(wsum % 8'd3);
      x_ext    = {{(24-DW){x_reg[in_idx][DW-1]}}, x_reg[in_idx]};
      term     = '0;
      if (wsel == 2'd2)
         term = x_ext;
      else if (wsel == 2'd0)
         term = -x_ext;
      acc_next = acc + term;
      if (acc_next > 24'sd32767)
         neuron = 16'h7FFF;
      else if (acc_next < -24'sd32768)
         neuron = 16'h8000;
      else
         neuron = acc_next[DW-1:0];
      if (act_en && neuron[DW-1])
         neuron = '0;
      last_in  = (in_idx == IW'(N_IN - 1));
      last_out = (out_idx == OW'(N_OUT - 1));
   end

   // Layer sequencer: latch inputs, sweep inputs per neuron, hold results until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         in_idx  <= '0;
         out_idx <= '0;
         acc     <= '0;
         for (int i = 0; i < N_IN; i++)  x_reg[i] <= '0;
         for (int o = 0; o < N_OUT; o++) res[o]   <= '0;
      end else if (clr) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         in_idx  <= '0;
         out_idx <= '0;
         acc     <= '0;
         for (int o = 0; o < N_OUT; o++) res[o] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < N_IN; i++) x_reg[i] <= in_vec[i*DW +: DW];
                  state   <= RUN;
                  busy    <= 1'b1;
                  in_idx  <= '0;
                  out_idx <= '0;
                  acc     <= '0;
               end
            end
            RUN: begin
               if (last_in) begin
                  res[out_idx] <= neuron;
                  acc          <= '0;
                  in_idx       <= '0;
                  if (last_out) begin
                     state   <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     out_idx <= '0;
                  end else begin
                     out_idx <= out_idx + OW'(1);
                  end
               end else begin
                  acc    <= acc_next;
                  in_idx <= in_idx + IW'(1);
               end
            end
            DONE: begin
               if (take) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < N_OUT; g++) begin : g_out
      assign out_vec[g*DW +: DW] = res[g];
   end
endmodule

module cnn_accel_wrapper #(
   parameter int DATA_WIDTH  = 16,
   parameter int IN_CHANNELS = 4,
   parameter int L1_IN       = 8,
   parameter int L1_OUT      = 4,
   parameter int L2_OUT      = 4,
   parameter int L3_OUT      = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ENABLE_PE,
   input  logic [DATA_WIDTH-1:0] bram_image_in,
   input  logic                  write_pixel_ready,
   output logic                  bram_en,
   output logic [1:0]            current_channel_out,
   output logic                  num_shifts_flag_pe1,
   input  logic                  fc_network_enable,
   input  logic                  fc_output_ready,
   input  logic                  fc_l1_activation_enable,
   input  logic                  fc_l2_activation_enable,
   input  logic                  fc_l3_activation_enable,
   input  logic                  fc_pipeline_reset,
   output logic                  fc_pipeline_busy,
   output logic                  fc_pipeline_stalled,
   output logic                  fc_pipeline_ready,
   output logic                  fc_l1_busy,
   output logic                  fc_l2_busy,
   output logic                  fc_l3_busy,
   output logic [DATA_WIDTH-1:0] fc_output_data,
   output logic                  fc_output_valid
);
   localparam int DW   = DATA_WIDTH;
   localparam int CW   = $clog2(IN_CHANNELS);
   localparam int SUMW = DW + CW;
   localparam int SW   = $clog2(L1_IN);
   localparam int RW   = $clog2(L3_OUT);
   localparam int NW   = $clog2(L3_OUT + 1);

   // rst_n is an active-high reset despite its name
   logic rst;
   assign rst = rst_n;

   logic [CW-1:0]            channel;
   logic signed [SUMW-1:0]   sum;
   logic signed [SUMW-1:0]   sum_next;
   logic signed [SUMW-1:0]   avg;
   logic [DW-1:0]            feature;
   logic [SW-1:0]            slot;
   logic [L1_IN*DW-1:0]      vec;
   logic                     vec_full;
   logic                     accept;
   logic                     handoff;

   logic                     l1_done, l2_done, l3_done;
   logic                     l1_idle, l2_idle, l3_idle;
   logic                     l1_take, l2_take, l3_take;
   logic [L1_OUT*DW-1:0]     l1_out;
   logic [L2_OUT*DW-1:0]     l2_out;
   logic [L3_OUT*DW-1:0]     l3_out;

   logic [DW-1:0]            obuf [L3_OUT];
   logic [RW-1:0]            rd;
   logic [NW-1:0]            cnt;
   logic                     out_empty;

   assign bram_en             = ENABLE_PE & ~vec_full & ~rst;
   assign accept              = bram_en & write_pixel_ready;
   assign current_channel_out = 2'(channel);

   assign l1_idle   = ~fc_l1_busy & ~l1_done;
   assign l2_idle   = ~fc_l2_busy & ~l2_done;
   assign l3_idle   = ~fc_l3_busy & ~l3_done;
   assign out_empty = (cnt == '0);

   assign handoff = vec_full & l1_idle & fc_network_enable;
   assign l1_take = l1_done & l2_idle & fc_network_enable;
   assign l2_take = l2_done & l3_idle & out_empty & fc_network_enable;
   assign l3_take = l3_done & out_empty & fc_network_enable;

   assign fc_pipeline_ready   = l1_idle & ~rst;
   assign fc_pipeline_busy    = fc_l1_busy | fc_l2_busy | fc_l3_busy | ~out_empty;
   assign fc_pipeline_stalled = (l1_done & ~l1_take) | (l2_done & ~l2_take) | (l3_done & ~l3_take);
   assign fc_output_valid     = ~out_empty;

   // Channel-group average with ReLU; the shift divides by the channel count.
   always_comb begin
      sum_next = sum + {{CW{bram_image_in[DW-1]}}, bram_image_in};
      avg      = sum_next >>> CW;
      feature  = avg[SUMW-1] ? '0 : avg[DW-1:0];
   end

   // Conv front-end: accumulate channels, pack features into the vector, flag completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum                 <= '0;
         channel             <= '0;
         slot                <= '0;
         vec                 <= '0;
         vec_full            <= 1'b0;
         num_shifts_flag_pe1 <= 1'b0;
      end else begin
         num_shifts_flag_pe1 <= 1'b0;
         if (handoff)
            vec_full <= 1'b0;
         if (accept) begin
            if (channel == CW'(IN_CHANNELS - 1)) begin
               channel             <= '0;
               sum                 <= '0;
               vec[slot*DW +: DW]  <= feature;
               if (slot == SW'(L1_IN - 1)) begin
                  slot                <= '0;
                  vec_full            <= 1'b1;
                  num_shifts_flag_pe1 <= 1'b1;
               end else begin
                  slot <= slot + SW'(1);
               end
            end else begin
               channel <= channel + CW'(1);
               sum     <= sum_next;
            end
         end
      end
   end

   fc_layer #(.N_IN(L1_IN), .N_OUT(L1_OUT), .DW(DW)) u_l1 (
      .clk(clk), .rst(rst), .clr(fc_pipeline_reset), .start(handoff),
      .act_en(fc_l1_activation_enable), .take(l1_take), .in_vec(vec),
      .busy(fc_l1_busy), .done(l1_done), .out_vec(l1_out)
   );

   fc_layer #(.N_IN(L1_OUT), .N_OUT(L2_OUT), .DW(DW)) u_l2 (
      .clk(clk), .rst(rst), .clr(fc_pipeline_reset), .start(l1_take),
      .act_en(fc_l2_activation_enable), .take(l2_take), .in_vec(l1_out),
      .busy(fc_l2_busy), .done(l2_done), .out_vec(l2_out)
   );

   fc_layer #(.N_IN(L2_OUT), .N_OUT(L3_OUT), .DW(DW)) u_l3 (
      .clk(clk), .rst(rst), .clr(fc_pipeline_reset), .start(l2_take),
      .act_en(fc_l3_activation_enable), .take(l3_take), .in_vec(l2_out),
      .busy(fc_l3_busy), .done(l3_done), .out_vec(l3_out)
   );

   // Output buffer: load all layer-3 words at once, then drain one per accepted cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         rd  <= '0;
         for (int k = 0; k < L3_OUT; k++) obuf[k] <= '0;
      end else if (fc_pipeline_reset) begin
         cnt <= '0;
         rd  <= '0;
      end else if (l3_take) begin
         for (int k = 0; k < L3_OUT; k++) obuf[k] <= l3_out[k*DW +: DW];
         cnt <= NW'(L3_OUT);
         rd  <= '0;
      end else if (fc_output_valid && fc_output_ready) begin
         cnt <= cnt - NW'(1);
         rd  <= rd + RW'(1);
      end
   end

   // Present the current word only while it is valid so idle data reads as zero.
   always_comb begin
      fc_output_data = '0;
      if (fc_output_valid)
         fc_output_data = obuf[rd];
   end
endmodule

// File: tb/tb_cnn_accel_wrapper.sv
// Self-checking bench for cnn_accel_wrapper: directed feature/ReLU/ones vectors,
// backpressure, a randomized throughput run and a mid-run reset, all scored
// against an arithmetic model of the network.
module tb_cnn_accel_wrapper;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        ENABLE_PE;
   logic [15:0] bram_image_in;
   logic        write_pixel_ready;
   logic        bram_en;
   logic [1:0]  current_channel_out;
   logic        num_shifts_flag_pe1;
   logic        fc_network_enable;
   logic        fc_output_ready;
   logic        fc_l1_activation_enable;
   logic        fc_l2_activation_enable;
   logic        fc_l3_activation_enable;
   logic        fc_pipeline_reset;
   logic        fc_pipeline_busy;
   logic        fc_pipeline_stalled;
   logic        fc_pipeline_ready;
   logic        fc_l1_busy;
   logic        fc_l2_busy;
   logic        fc_l3_busy;
   logic [15:0] fc_output_data;
   logic        fc_output_valid;

   int          compared   = 0;
   int          mismatched = 0;
   int          ch_sum     = 0;
   int          ch_n       = 0;
   int          feats[$];
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   cnn_accel_wrapper dut (
      .clk(clk), .rst_n(rst_n), .ENABLE_PE(ENABLE_PE), .bram_image_in(bram_image_in),
      .write_pixel_ready(write_pixel_ready), .bram_en(bram_en),
      .current_channel_out(current_channel_out), .num_shifts_flag_pe1(num_shifts_flag_pe1),
      .fc_network_enable(fc_network_enable), .fc_output_ready(fc_output_ready),
      .fc_l1_activation_enable(fc_l1_activation_enable),
      .fc_l2_activation_enable(fc_l2_activation_enable),
      .fc_l3_activation_enable(fc_l3_activation_enable),
      .fc_pipeline_reset(fc_pipeline_reset), .fc_pipeline_busy(fc_pipeline_busy),
      .fc_pipeline_stalled(fc_pipeline_stalled), .fc_pipeline_ready(fc_pipeline_ready),
      .fc_l1_busy(fc_l1_busy), .fc_l2_busy(fc_l2_busy), .fc_l3_busy(fc_l3_busy),
      .fc_output_data(fc_output_data), .fc_output_valid(fc_output_valid)
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int weight(input int i, input int o);
      return ((i + 2 * o) % 3) - 1;
   endfunction

   function automatic int clamp_act(input int v, input bit act);
      int r;
      r = v;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      if (act && r < 0) r = 0;
      return r;
   endfunction

   function automatic void run_layer(input int x[$], input int n_out, input bit act, output int y[$]);
      y = {};
      for (int o = 0; o < n_out; o++) begin
         int s;
         s = 0;
         for (int i = 0; i < x.size(); i++) s += weight(i, o) * x[i];
         y.push_back(clamp_act(s, act));
      end
   endfunction

   // Reference: average 4 pixels into a ReLU feature, 8 features form a vector for 3 layers
   task automatic model_pixel(input logic [15:0] p);
      int f;
      int h1[$];
      int h2[$];
      int y[$];
      ch_sum += int'($signed(p));
      ch_n++;
      if (ch_n == 4) begin
         f = ch_sum >>> 2;
         if (f < 0) f = 0;
         feats.push_back(f);
         ch_sum = 0;
         ch_n   = 0;
         if (feats.size() == 8) begin
            run_layer(feats, 4, fc_l1_activation_enable, h1);
            run_layer(h1, 4, fc_l2_activation_enable, h2);
            run_layer(h2, 3, fc_l3_activation_enable, y);
            foreach (y[k]) exp_q.push_back(16'(y[k]));
            feats = {};
         end
      end
   endtask

   function automatic logic [15:0] word_at(input int k);
      if (k < got_q.size()) return got_q[k];
      return 16'hxxxx;
   endfunction

   // One clock: drive at negedge, observe handshakes, return #1 after the posedge
   task automatic tick(input bit pv, input logic [15:0] px, input bit rdy, output bit took);
      logic [15:0] want;
      @(negedge clk);
      write_pixel_ready = pv;
      bram_image_in     = px;
      fc_output_ready   = rdy;
      #1;
      took = bram_en && write_pixel_ready;
      if (took) model_pixel(px);
      if (fc_output_valid && fc_output_ready) begin
         want = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
         got_q.push_back(fc_output_data);
         check_output("output_word", 32'(fc_output_data), 32'(want));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [15:0] px, input int gap, input bit rdy);
      bit took;
      int n;
      for (int g = 0; g < gap; g++) tick(1'b0, 16'h0, rdy, took);
      took = 1'b0;
      n    = 0;
      while (!took && n < 400) begin
         tick(1'b1, px, rdy, took);
         n++;
      end
      check_output("pixel_accept", 32'(took), 32'd1);
   endtask

   task automatic drain(input int budget);
      bit took;
      int n;
      n = 0;
      while ((exp_q.size() != 0 || fc_pipeline_busy || !bram_en) && n < budget) begin
         tick(1'b0, 16'h0, 1'b1, took);
         n++;
      end
      check_output("drain_in_time", 32'(n < budget), 32'd1);
   endtask

   initial begin
      bit          took;
      int          n;
      int          words0;
      logic [15:0] held;

      rst_n = 1'b1; ENABLE_PE = 1'b1; bram_image_in = '0; write_pixel_ready = 1'b0;
      fc_network_enable = 1'b0; fc_output_ready = 1'b0; fc_pipeline_reset = 1'b0;
      fc_l1_activation_enable = 1'b1; fc_l2_activation_enable = 1'b1; fc_l3_activation_enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("[TB] reset state");
      check_output("rst_bram_en", 32'(bram_en), 0);
      check_output("rst_channel", 32'(current_channel_out), 0);
      check_output("rst_flag", 32'(num_shifts_flag_pe1), 0);
      check_output("rst_valid", 32'(fc_output_valid), 0);
      check_output("rst_data", 32'(fc_output_data), 0);
      check_output("rst_busy", 32'(fc_pipeline_busy), 0);
      check_output("rst_stalled", 32'(fc_pipeline_stalled), 0);
      check_output("rst_ready", 32'(fc_pipeline_ready), 0);
      check_output("rst_layer_busy", 32'({fc_l1_busy, fc_l2_busy, fc_l3_busy}), 0);

      rst_n = 1'b0; fc_network_enable = 1'b1; fc_output_ready = 1'b1;
      @(posedge clk);
      #1;
      check_output("ready_after_reset", 32'(fc_pipeline_ready), 1);
      check_output("bram_en_after_reset", 32'(bram_en), 1);

      $display("[TB] channel averaging and feature ReLU");
      got_q = {};
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(16'((k + 1) * 256), 0, 1'b1);
         check_output("channel_step", 32'(current_channel_out), 32'(ch_n));
      end
      for (int k = 0; k < 4; k++) apply_stimulus(16'hFF00, 0, 1'b1);
      check_output("channel_wrap", 32'(current_channel_out), 0);
      for (int k = 0; k < 24; k++) apply_stimulus(16'h0100, 0, 1'b1);
      check_output("vector_flag", 32'(num_shifts_flag_pe1), 1);
      check_output("vector_full_blocks", 32'(bram_en), 0);
      tick(1'b0, 16'h0, 1'b1, took);
      check_output("vector_flag_pulse", 32'(num_shifts_flag_pe1), 0);
      drain(600);
      check_output("feat_word_count", 32'(got_q.size()), 3);
      check_output("feat_word0", 32'(word_at(0)), 32'h0280);
      check_output("feat_word1", 32'(word_at(1)), 32'h0000);
      check_output("feat_word2", 32'(word_at(2)), 32'hFD80);

      $display("[TB] ones vector, layer-3 activation off then on");
      for (int pass = 0; pass < 2; pass++) begin
         fc_l3_activation_enable = (pass == 1);
         got_q = {};
         for (int k = 0; k < 32; k++) apply_stimulus(16'h0100, 0, 1'b1);
         drain(600);
         check_output("ones_word_count", 32'(got_q.size()), 3);
         check_output("ones_word0", 32'(word_at(0)), (pass == 1) ? 32'h0000 : 32'hFE00);
         check_output("ones_word1", 32'(word_at(1)), 32'h0200);
         check_output("ones_word2", 32'(word_at(2)), 32'h0000);
      end

      $display("[TB] output backpressure");
      fc_l3_activation_enable = 1'b0;
      n = 0;
      while (!fc_output_valid && n < 600) begin
         tick(1'b1, 16'($urandom), 1'b0, took);
         n++;
      end
      check_output("bp_valid_seen", 32'(fc_output_valid), 1);
      held = fc_output_data;
      for (int k = 0; k < 20; k++) begin
         tick(1'b1, 16'($urandom), 1'b0, took);
         check_output("bp_valid_held", 32'(fc_output_valid), 1);
         check_output("bp_data_stable", 32'(fc_output_data), 32'(held));
      end
      n = 0;
      while (!fc_pipeline_stalled && n < 600) begin
         tick(1'b1, 16'($urandom), 1'b0, took);
         n++;
      end
      check_output("bp_stalled", 32'(fc_pipeline_stalled), 1);
      drain(1500);

      $display("[TB] random throughput");
      fc_l1_activation_enable = 1'($urandom);
      fc_l2_activation_enable = 1'($urandom);
      fc_l3_activation_enable = 1'($urandom);
      got_q  = {};
      for (int k = 0; k < 1000; k++)
         apply_stimulus(16'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
      drain(1500);
      words0 = got_q.size();
      check_output("tp_min_outputs", 32'(words0 >= 5), 1);
      check_output("tp_no_lost_words", 32'(exp_q.size()), 0);

      $display("[TB] conv freeze with ENABLE_PE low");
      ENABLE_PE = 1'b0;
      tick(1'b1, 16'h1234, 1'b1, took);
      check_output("freeze_bram_en", 32'(bram_en), 0);
      check_output("freeze_no_accept", 32'(took), 0);
      check_output("freeze_channel", 32'(current_channel_out), 32'(ch_n));
      ENABLE_PE = 1'b1;

      $display("[TB] reset mid-run");
      n = 0;
      while (!fc_output_valid && n < 600) begin
         tick(1'b1, 16'h0300, 1'b0, took);
         n++;
      end
      check_output("mid_valid_before", 32'(fc_output_valid), 1);
      rst_n = 1'b1;
      #1;
      check_output("mid_bram_en", 32'(bram_en), 0);
      check_output("mid_channel", 32'(current_channel_out), 0);
      check_output("mid_valid", 32'(fc_output_valid), 0);
      check_output("mid_data", 32'(fc_output_data), 0);
      check_output("mid_busy", 32'(fc_pipeline_busy), 0);
      check_output("mid_ready", 32'(fc_pipeline_ready), 0);
      ch_sum = 0; ch_n = 0; feats = {}; exp_q = {};
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_output("mid_ready_after", 32'(fc_pipeline_ready), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
